// File: rtl/fp_add_pipe.sv
// Three-stage pipelined IEEE-754 adder/subtractor with valid/ready handshake.
// Stages: unpack/swap/align -> add/sub -> normalise/round/pack.
module fp_add_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in_a,
  input  logic [EXP_W+MAN_W:0]   in_b,
  input  logic                   in_sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_sum,
  output logic [3:0]             out_flags
);

  localparam int W   = EXP_W + MAN_W + 1;
  localparam int M   = MAN_W + 3;
  localparam int MW  = MAN_W + 2;
  localparam int LZW = $clog2(M + 2);
  localparam int EW  = EXP_W + LZW + 1;
  localparam logic [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);
  localparam logic [W-1:0]  QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  function automatic logic [LZW-1:0] lzc(input logic [M:0] v);
    logic found;
    lzc   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i <= M; i++) begin
      if (!found) begin
        if (v[M-i]) found = 1'b1;
        else        lzc   = lzc + LZW'(1);
      end
    end
  endfunction

  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // ---------------- S1: unpack, specials, swap, align ----------------
  logic               signA, signB, zeroA, zeroB, nanA, nanB, infA, infB, swap;
  logic [EXP_W-1:0]   expA, expB, expL, expS, diff;
  logic [MAN_W-1:0]   fracA, fracB;
  logic [W-2:0]       keyA, keyB;
  logic [M-1:0]       mantA, mantB, mantL, mantS, aligned;
  logic [2*M-1:0]     ext;
  logic               sticky, specNan, specOn;
  logic [W-1:0]       specSum;

  always_comb begin
    signA = in_a[W-1];
    expA  = in_a[W-2:MAN_W];
    fracA = in_a[MAN_W-1:0];
    signB = in_b[W-1] ^ in_sub;
    expB  = in_b[W-2:MAN_W];
    fracB = in_b[MAN_W-1:0];
    zeroA = (expA == '0);
    zeroB = (expB == '0);
    nanA  = (&expA) && (|fracA);
    nanB  = (&expB) && (|fracB);
    infA  = (&expA) && !(|fracA);
    infB  = (&expB) && !(|fracB);
    // Subnormals flush to zero, so their fraction must not win the compare.
    keyA  = zeroA ? '0 : {expA, fracA};
    keyB  = zeroB ? '0 : {expB, fracB};
    mantA = zeroA ? '0 : {1'b1, fracA, 2'b00};
    mantB = zeroB ? '0 : {1'b1, fracB, 2'b00};
    swap  = keyB > keyA;
    expL  = swap ? expB  : expA;
    expS  = swap ? expA  : expB;
    mantL = swap ? mantB : mantA;
    mantS = swap ? mantA : mantB;
    diff  = expL - expS;
    ext   = {mantS, {M{1'b0}}} >> diff;
    if (int'(diff) >= M) begin
      aligned = '0;
      sticky  = |mantS;
    end else begin
      aligned = ext[2*M-1:M];
      sticky  = |ext[M-1:0];
    end
    specNan = nanA || nanB || (infA && infB && (signA != signB));
    specOn  = specNan || infA || infB;
    if (specNan)   specSum = QNAN;
    else if (infA) specSum = {signA, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else           specSum = {signB, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
  end

  logic             s1Valid, s1Spec, s1SpecNan, s1Sign, s1ZeroSign, s1EffSub, s1Sticky;
  logic [W-1:0]     s1SpecSum;
  logic [EXP_W-1:0] s1Exp;
  logic [M-1:0]     s1MantL, s1MantS;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1Valid <= 1'b0;
    end else if (en) begin
      s1Valid    <= in_valid;
      s1Spec     <= specOn;
      s1SpecNan  <= specNan;
      s1SpecSum  <= specSum;
      s1Sign     <= swap ? signB : signA;
      s1ZeroSign <= signA & signB;
      s1EffSub   <= signA ^ signB;
      s1Exp      <= expL;
      s1MantL    <= mantL;
      s1MantS    <= aligned;
      s1Sticky   <= sticky;
    end
  end

  // ---------------- S2: magnitude add/subtract ----------------
  // Sticky rides as an extra LSB so a subtract borrows correctly for rounding.
  logic [M+1:0] sumC;

  always_comb begin
    if (s1EffSub) sumC = {1'b0, s1MantL, 1'b0} - {1'b0, s1MantS, s1Sticky};
    else          sumC = {1'b0, s1MantL, 1'b0} + {1'b0, s1MantS, s1Sticky};
  end

  logic             s2Valid, s2Spec, s2SpecNan, s2Sign, s2ZeroSign;
  logic [W-1:0]     s2SpecSum;
  logic [EXP_W-1:0] s2Exp;
  logic [M+1:0]     s2Sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2Valid <= 1'b0;
    end else if (en) begin
      s2Valid    <= s1Valid;
      s2Spec     <= s1Spec;
      s2SpecNan  <= s1SpecNan;
      s2SpecSum  <= s1SpecSum;
      s2Sign     <= s1Sign;
      s2ZeroSign <= s1ZeroSign;
      s2Exp      <= s1Exp;
      s2Sum      <= sumC;
    end
  end

  // ---------------- S3: normalise, round, pack ----------------
  logic             carry, guardB, restB, roundUp, inexact;
  logic [LZW-1:0]   lz;
  logic [M:0]       norm;
  logic [EW-1:0]    expWide, eNorm, eRound;
  logic [MW-1:0]    mantR;
  logic [MAN_W-1:0] fracR;
  logic [W-1:0]     resSum;
  logic [3:0]       resFlags;

  always_comb begin
    carry   = s2Sum[M+1];
    lz      = lzc(s2Sum[M:0]);
    norm    = carry ? {s2Sum[M+1:2], s2Sum[1] | s2Sum[0]} : (s2Sum[M:0] << lz);
    expWide = {{(EW-EXP_W){1'b0}}, s2Exp};
    eNorm   = carry ? expWide + EW'(1) : expWide - EW'(lz);
    guardB  = norm[2];
    restB   = norm[1] | norm[0];
    roundUp = guardB && (restB || norm[3]);
    inexact = guardB || restB;
    mantR   = {1'b0, norm[M:3]} + MW'(roundUp);
    eRound  = eNorm + EW'(mantR[MAN_W+1]);
    fracR   = mantR[MAN_W+1] ? mantR[MAN_W:1] : mantR[MAN_W-1:0];
    resSum   = '0;
    resFlags = '0;
    if (s2Spec) begin
      resSum   = s2SpecSum;
      resFlags = {s2SpecNan, 3'b000};
    end else if (s2Sum == '0) begin
      resSum = {s2ZeroSign, {(W-1){1'b0}}};
    end else if (eRound[EW-1] || eRound == '0) begin
      resSum   = {s2Sign, {(W-1){1'b0}}};
      resFlags = 4'b0011;
    end else if (eRound >= EXP_MAX) begin
      resSum   = {s2Sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      resFlags = 4'b0101;
    end else begin
      resSum   = {s2Sign, eRound[EXP_W-1:0], fracR};
      resFlags = {3'b000, inexact};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_flags <= '0;
    end else if (en) begin
      out_valid <= s2Valid;
      if (s2Valid) begin
        out_sum   <= resSum;
        out_flags <= resFlags;
      end
    end
  end

endmodule

// File: tb/tb_fp_add_pipe.sv
// Scoreboard bench for fp_add_pipe (single precision): directed beats,
// back-pressured stream and mid-flight reset.
module tb_fp_add_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a, in_b;
  logic        in_sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic [3:0]  out_flags;

  fp_add_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_flags(out_flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] sum;
    logic [3:0]  flags;
    int unsigned acc;
    bit          lat;
  } exp_t;

  exp_t        sbq[$];
  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned cnt      = 0;
  logic [31:0] drvSum;
  logic [3:0]  drvFlags;
  bit          drvLat;

  logic [31:0] stA   [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                             32'h41200000, 32'h3F800000, 32'hC0000000, 32'h3F000000};
  logic [31:0] stB   [8] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
                             32'h40A00000, 32'h40000000, 32'hC0000000, 32'h3F000000};
  logic        stSub [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [31:0] stExp [8] = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40400000,
                             32'h41700000, 32'hBF800000, 32'hC0800000, 32'h3F800000};

  always @(posedge clk) cnt <= cnt + 1;

  // Output monitor and input acceptance, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        checks++;
        assert (sbq.size() > 0) else begin
          failures++;
          $error("FAIL unexpected_out observed=%h expected=no_output", out_sum);
        end
        if (sbq.size() > 0) begin
          checks++;
          assert (out_sum === sbq[0].sum) else begin
            failures++;
            $error("FAIL sum observed=%h expected=%h", out_sum, sbq[0].sum);
          end
          checks++;
          assert (out_flags === sbq[0].flags) else begin
            failures++;
            $error("FAIL flags observed=%b expected=%b (sum %h)", out_flags, sbq[0].flags, sbq[0].sum);
          end
          if (out_ready) begin
            if (sbq[0].lat) begin
              checks++;
              assert (cnt - sbq[0].acc == 3) else begin
                failures++;
                $error("FAIL latency observed=%0d expected=3", cnt - sbq[0].acc);
              end
            end
            void'(sbq.pop_front());
          end
        end
        if (!out_ready) begin
          checks++;
          assert (in_ready === 1'b0) else begin
            failures++;
            $error("FAIL in_ready_stall observed=%b expected=0", in_ready);
          end
        end
      end else begin
        checks++;
        assert (in_ready === 1'b1) else begin
          failures++;
          $error("FAIL in_ready_idle observed=%b expected=1", in_ready);
        end
      end
      if (in_valid && in_ready)
        sbq.push_back('{sum: drvSum, flags: drvFlags, acc: cnt, lat: drvLat});
    end
  end

  task automatic sendBeat(input logic [31:0] a, input logic [31:0] b, input logic sub,
                          input logic [31:0] es, input logic [3:0] ef);
    bit taken = 1'b0;
    in_a = a; in_b = b; in_sub = sub;
    drvSum = es; drvFlags = ef; drvLat = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !taken; i++) begin
      @(negedge clk);
      taken = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++;
    assert (taken) else begin
      failures++;
      $error("FAIL accept_timeout observed=not_accepted expected=accepted (a=%h)", a);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sbq.size() > 0; i++) begin
      @(posedge clk); #1;
    end
    checks++;
    assert (sbq.size() == 0) else begin
      failures++;
      $error("FAIL drain observed=%0d_pending expected=0_pending", sbq.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned idx;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b1;
    drvSum = '0; drvFlags = '0; drvLat = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    checks++;
    assert (out_valid === 1'b0) else begin failures++; $error("FAIL rst_valid observed=%b expected=0", out_valid); end
    checks++;
    assert (out_sum === 32'h0) else begin failures++; $error("FAIL rst_sum observed=%h expected=00000000", out_sum); end
    checks++;
    assert (out_flags === 4'h0) else begin failures++; $error("FAIL rst_flags observed=%b expected=0000", out_flags); end
    checks++;
    assert (in_ready === 1'b1) else begin failures++; $error("FAIL rst_ready observed=%b expected=1", in_ready); end

    // Directed single beats.
    sendBeat(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000); drain();
    sendBeat(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000); drain();
    sendBeat(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000); drain();
    sendBeat(32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 4'b0000); drain();
    sendBeat(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101); drain();
    sendBeat(32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b1000); drain();
    sendBeat(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000); drain();
    sendBeat(32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000); drain();
    sendBeat(32'h3F800000, 32'hFF800000, 1'b0, 32'hFF800000, 4'b0000); drain();
    sendBeat(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001); drain();
    sendBeat(32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 4'b0001); drain();
    sendBeat(32'h00400000, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0000); drain();
    sendBeat(32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b0011); drain();

    // Back-to-back stream under back-pressure.
    idx = 0;
    drvLat = 1'b0;
    for (int unsigned c = 0; c < 60 && (idx < 8 || c < 14); c++) begin
      out_ready = (c < 8) ? (c % 2 == 0) : (c >= 13);
      if (idx < 8) begin
        in_a = stA[idx]; in_b = stB[idx]; in_sub = stSub[idx];
        drvSum = stExp[idx]; drvFlags = 4'b0000;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++;
    assert (idx == 8) else begin failures++; $error("FAIL stream_accepted observed=%0d expected=8", idx); end
    drain();

    // Reset with two beats in flight.
    in_a = 32'h3F800000; in_b = 32'h3F800000; in_sub = 1'b0;
    drvSum = 32'h40000000; drvFlags = 4'b0000; drvLat = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_a = 32'h40000000; drvSum = 32'h40400000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    sbq.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      assert (out_valid === 1'b0) else begin
        failures++;
        $error("FAIL flushed_valid observed=%b expected=0", out_valid);
      end
    end
    @(posedge clk); #1;
    sendBeat(32'h40400000, 32'h3F800000, 1'b0, 32'h40800000, 4'b0000); drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
